// File: rtl/perf_counter_reader.sv
// Snapshots three performance counters on request and streams them as an 11-byte
// frame (header, three 24-bit counters MSB first, XOR checksum) over valid/ready.
module perf_counter_reader #(
  parameter int unsigned CNT_W         = 20,
  parameter logic [7:0]  HEADER        = 8'hA5,
  parameter bit          CLEAR_ON_READ = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  input  logic [CNT_W-1:0] i_inst_count,
  input  logic [CNT_W-1:0] i_ma_count,
  input  logic [CNT_W-1:0] i_mc_count,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_valid,
  input  logic             i_tx_ready,
  output logic             o_busy,
  output logic             o_cnt_clr,
  output logic             o_frame_done
);

  typedef enum logic {StIdle, StSend} state_e;

  state_e      r_state, w_state_d;
  logic [3:0]  r_idx, w_idx_d;
  logic [71:0] r_snap, w_snap_d;
  logic [7:0]  r_chk, w_chk_d;
  logic        r_clr, w_clr_d;
  logic        r_done, w_done_d;

  logic [23:0] w_inst_ext, w_ma_ext, w_mc_ext;
  logic [7:0]  w_cur_byte, w_next_byte;

  // Byte idx of the frame; snapshot packs inst, ma, mc from MSB down.
  function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                            input logic [71:0] snap,
                                            input logic [7:0]  chk);
    logic [7:0] b;
    case (idx)
      4'd0:    b = HEADER;
      4'd1:    b = snap[71:64];
      4'd2:    b = snap[63:56];
      4'd3:    b = snap[55:48];
      4'd4:    b = snap[47:40];
      4'd5:    b = snap[39:32];
      4'd6:    b = snap[31:24];
      4'd7:    b = snap[23:16];
      4'd8:    b = snap[15:8];
      4'd9:    b = snap[7:0];
      default: b = chk;
    endcase
    return b;
  endfunction

  always_comb begin
    w_inst_ext = '0;
    w_ma_ext   = '0;
    w_mc_ext   = '0;
    w_inst_ext[CNT_W-1:0] = i_inst_count;
    w_ma_ext[CNT_W-1:0]   = i_ma_count;
    w_mc_ext[CNT_W-1:0]   = i_mc_count;
  end

  assign w_cur_byte  = frame_byte(r_idx, r_snap, r_chk);
  assign w_next_byte = frame_byte(r_idx + 4'd1, r_snap, r_chk);

  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_snap_d  = r_snap;
    w_chk_d   = r_chk;
    w_clr_d   = 1'b0;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req) begin
          w_state_d = StSend;
          w_idx_d   = 4'd0;
          w_snap_d  = {w_inst_ext, w_ma_ext, w_mc_ext};
          w_chk_d   = HEADER;
          w_clr_d   = CLEAR_ON_READ;
        end
      end
      StSend: begin
        if (i_tx_ready) begin
          if (r_idx == 4'd10) begin
            w_state_d = StIdle;
            w_idx_d   = 4'd0;
            w_done_d  = 1'b1;
          end else begin
            w_idx_d = r_idx + 4'd1;
            // Checksum covers bytes 0..9; it is frozen once byte 9 goes out.
            if (r_idx < 4'd9) w_chk_d = r_chk ^ w_next_byte;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_idx   <= 4'd0;
      r_snap  <= '0;
      r_chk   <= 8'd0;
      r_clr   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
      r_snap  <= w_snap_d;
      r_chk   <= w_chk_d;
      r_clr   <= w_clr_d;
      r_done  <= w_done_d;
    end
  end

  assign o_busy       = (r_state == StSend);
  assign o_tx_valid   = (r_state == StSend);
  assign o_tx_data    = (r_state == StSend) ? w_cur_byte : 8'd0;
  assign o_cnt_clr    = r_clr;
  assign o_frame_done = r_done;

endmodule

// File: tb/tb_perf_counter_reader.sv
// Scoreboard bench for perf_counter_reader: expected frame bytes are queued at the
// capture edge and checked against every transferred byte.
module tb_perf_counter_reader;

  logic        clk;
  logic        rst;
  logic        req;
  logic [19:0] inst, ma, mc;
  logic        tx_ready;

  logic [7:0]  tx_data0, tx_data1;
  logic        tx_valid0, tx_valid1, busy0, busy1, clr0, clr1, done0, done1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] sb[$];  // {last_byte, byte}
  logic [7:0] exp_bytes[11];
  logic       pend_done = 1'b0;

  perf_counter_reader #(.CNT_W(20), .HEADER(8'hA5), .CLEAR_ON_READ(1'b0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .i_inst_count(inst), .i_ma_count(ma), .i_mc_count(mc),
    .o_tx_data(tx_data0), .o_tx_valid(tx_valid0), .i_tx_ready(tx_ready),
    .o_busy(busy0), .o_cnt_clr(clr0), .o_frame_done(done0)
  );

  perf_counter_reader #(.CNT_W(20), .HEADER(8'hA5), .CLEAR_ON_READ(1'b1)) u_dut_clr (
    .i_clk(clk), .i_rst(rst), .i_req(req),
    .i_inst_count(inst), .i_ma_count(ma), .i_mc_count(mc),
    .o_tx_data(tx_data1), .o_tx_valid(tx_valid1), .i_tx_ready(tx_ready),
    .o_busy(busy1), .o_cnt_clr(clr1), .o_frame_done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic build_frame(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c);
    logic [71:0] s;
    logic [7:0]  x;
    s = {4'h0, a, 4'h0, b, 4'h0, c};
    exp_bytes[0] = 8'hA5;
    for (int i = 1; i < 10; i++) exp_bytes[i] = s[71-8*(i-1) -: 8];
    x = 8'h00;
    for (int i = 0; i < 10; i++) x = x ^ exp_bytes[i];
    exp_bytes[10] = x;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 11; i++) sb.push_back({(i == 10), exp_bytes[i]});
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 after the last transfer.
  task automatic run_frame(input logic [19:0] a, input logic [19:0] b, input logic [19:0] c,
                           input bit rnd_rdy, input bit churn, input bit xreq);
    int cyc;
    inst = a; ma = b; mc = c; req = 1'b1;
    build_frame(a, b, c);
    @(posedge clk); #1;
    req = 1'b0;
    push_frame();
    cyc = 0;
    while (sb.size() != 0 && cyc < 300) begin
      tx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (churn) begin
        inst = 20'($urandom); ma = 20'($urandom); mc = 20'($urandom);
      end
      req = xreq && ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      req = 1'b0;
      cyc++;
    end
    check_eq("frame_timeout", 32'(sb.size()), 0);
    tx_ready = 1'b1;
    check_eq("busy_after", 32'(busy0), 0);
    check_eq("valid_after", 32'(tx_valid0), 0);
  endtask

  always @(negedge clk) begin : monitor
    check_eq("clr_tied_low", 32'(clr0), 0);
    if (rst) begin
      sb.delete();
      pend_done <= 1'b0;
      check_eq("rst_valid", 32'(tx_valid0), 0);
      check_eq("rst_busy", 32'(busy0), 0);
      check_eq("rst_done", 32'(done0), 0);
    end else begin
      check_eq("frame_done", 32'(done0), 32'(pend_done));
      pend_done <= 1'b0;
      check_eq("busy", 32'(busy0), 32'(sb.size() != 0));
      check_eq("tx_valid", 32'(tx_valid0), 32'(sb.size() != 0));
      if (tx_valid0 && sb.size() != 0) begin
        check_eq("tx_data", 32'(tx_data0), 32'(sb[0][7:0]));
        if (tx_ready) begin
          pend_done <= sb[0][8];
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int cyc;
    rst = 1'b1; req = 1'b0; tx_ready = 1'b1;
    inst = '0; ma = '0; mc = '0;
    #12;
    check_eq("reset_data", 32'(tx_data0), 0);
    check_eq("reset_valid", 32'(tx_valid0), 0);
    check_eq("reset_busy", 32'(busy0), 0);
    check_eq("reset_clr1", 32'(clr1), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reference frame, then an immediate back-to-back frame, then all zeros.
    run_frame(20'h12345, 20'h00001, 20'hFFFFF, 1'b0, 1'b0, 1'b0);
    run_frame(20'h12345, 20'h00001, 20'hFFFFF, 1'b0, 1'b0, 1'b0);
    run_frame(20'h00000, 20'h00000, 20'h00000, 1'b0, 1'b0, 1'b0);
    // Random back-pressure.
    run_frame(20'h12345, 20'h00001, 20'hFFFFF, 1'b1, 1'b0, 1'b0);
    // Live counters churn and stray requests arrive mid-frame.
    run_frame(20'hABCDE, 20'h5A5A5, 20'h0F0F0, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Abort with reset after five bytes while stalled.
    inst = 20'h13579; ma = 20'h2468A; mc = 20'hFEDCB; req = 1'b1;
    build_frame(inst, ma, mc);
    @(posedge clk); #1;
    req = 1'b0;
    push_frame();
    cyc = 0;
    while (sb.size() > 6 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("abort_reach", 32'(sb.size()), 6);
    tx_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("abort_valid", 32'(tx_valid0), 0);
    check_eq("abort_busy", 32'(busy0), 0);
    check_eq("abort_data", 32'(tx_data0), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
    run_frame(20'h0BEEF, 20'h00C0D, 20'h7FFFF, 1'b0, 1'b0, 1'b0);

    // Clear-on-read instance: pulse only in the cycle after capture, snapshot intact.
    inst = 20'h0ABCD; ma = 20'h11111; mc = 20'h80001; req = 1'b1;
    build_frame(inst, ma, mc);
    @(negedge clk);
    check_eq("clr_pre", 32'(clr1), 0);
    @(posedge clk); #1;
    req = 1'b0;
    push_frame();
    inst = '0; ma = '0; mc = '0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k == 0) check_eq("clr_pulse", 32'(clr1), 1);
      if (k == 1) check_eq("clr_end", 32'(clr1), 0);
      check_eq("clr_dut_data", 32'(tx_data1), 32'(exp_bytes[k]));
    end
    cyc = 0;
    while (sb.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    check_eq("clr_frame_drain", 32'(sb.size()), 0);

    for (int n = 0; n < 3; n++)
      run_frame(20'($urandom), 20'($urandom), 20'($urandom), 1'b1, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
